bcd_conv_sched: RTL and testbench
=================================

// Module: bcd_conv_sched
// PURPOSE
//  Shares one multi-cycle binary-to-BCD converter between N_REQ requesters (score, timer,
//  counter fields feeding the 7-segment display path). Round-robin arbiter grants one
//  requester at a time. A serial double-dabble engine converts the 7-bit operand to
//  two BCD digits, one bit per cycle. Results are broadcast with a requester ID tag.
// PARAMETERS
//  N_REQ  4  number of requesters, range 2..8
//  BIN_W  7  operand width, range 4..7 (result is always 2 digits)
// PORTS
//  clk      in   1              system clock, rising edge
//  rst_n    in   1              reset; one clock, asynchronous, active-low
//  req      in   N_REQ          request; held high with operand stable until gnt seen
//  bin_in   in   N_REQ*BIN_W    operands; requester i at [i*BIN_W +: BIN_W]
//  gnt      out  N_REQ          one-hot, 1-cycle pulse: operand of requester i captured
//  busy     out  1              high from grant cycle through done cycle
//  done     out  1              1-cycle pulse: bcd1/bcd0/ovf/done_id valid (held after)
//  done_id  out  $clog2(N_REQ)  index of requester whose result is on bcd1/bcd0
//  bcd1     out  4              tens digit
//  bcd0     out  4              units digit
//  ovf      out  1              operand was >= 100; digits forced to 9,9
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; gnt=0, busy=0, done=0, done_id=0, bcd1=0,
//   bcd0=0, ovf=0; RR pointer=0 (req[0] highest); in-flight conversion dropped, no done.
//  FSM IDLE -> SHIFT -> DONE -> IDLE. All outputs registered.
//  IDLE: on an edge with |req: winner w = first set req at/after pointer (wrapping).
//   Capture bin_in[w]. If >= 100: load 99, set ovf_r; else load value, clear ovf_r.
//   Set gnt<=onehot(w), pointer<=w+1 (mod N_REQ), cnt<=0, clear digit regs, ->SHIFT.
//  SHIFT: gnt high only in the first SHIFT cycle; busy=1. Each edge does one iteration:
//   add 3 to any digit >= 5, then shift {d1,d0} left by 1, inserting operand bit
//   BIN_W-1-cnt. cnt++; after iteration BIN_W-1 -> DONE.
//  DONE: done=1 for one cycle; bcd1/bcd0/ovf/done_id update on the edge entering DONE
//   and hold until the next done. Next edge -> IDLE. No arbitration in DONE.
//  Timing: gnt in cycle c -> done in cycle c+BIN_W; back-to-back grants every BIN_W+2
//   cycles (9 at default).
//  Requester rules: may drop or change req/bin_in in the cycle after gnt. A req dropped
//   before grant is never granted. A req held after its grant is eligible again, at
//   lowest priority. A req arriving during SHIFT/DONE waits for IDLE.
//  Widths: digit regs 4 bit; the post-clamp operand (<=99) never overflows 2 digits.
//  A simultaneous req change in the capture edge: the sampled value wins.
// STRUCTURE
//  Shared include bcd_defs.vh: FSM state encodings (IDLE/SHIFT/DONE), BCD_MAX=99,
//   DIGIT_W=4.
//  Sub-module rr_arbiter (N_REQ): req + pointer -> one-hot winner + index; combinational;
//   pointer register stays in bcd_conv_sched. The FSM and dabble datapath stay inline.
// TESTING
//  1 req[0]=1, bin=57 -> gnt=0001 one cycle; done 7 cycles later, bcd1=5, bcd0=7,
//    done_id=0, ovf=0.
//  2 req=1111 at once, ops 0,99,100,42 -> grants 0,1,2,3, 9 cycles apart; results 0/0,
//    9/9, 9/9 with ovf=1, 4/2.
//  3 req[0], req[2] held high continuously -> grant order 0,2,0,2; req[1]/req[3] never
//    granted.
//  4 rst_n low in 3rd SHIFT cycle -> all outputs 0 at once, no done. After release,
//    req[1]=1, bin=13 -> gnt[1]; result 1/3.
//  5 Sweep 0..127 on req[3] -> bcd1=min(v,99)/10, bcd0=min(v,99)%10, ovf=(v>=100),
//    done_id=3.
//  6 Check: done and gnt never high in the same cycle, and busy=1 exactly from gnt
//    through done.

Source files
------------

// File: rtl/bcd_conv_sched_pkg.sv
// ----------------------------------------------------------------------------
// bcd_conv_sched_pkg : shared FSM encodings, BCD constants and dabble helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bcd_conv_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int BCD_MAX = 99;
  localparam int DIGIT_W = 4;

  // Double-dabble correction applied to a digit before each shift
  function automatic logic [DIGIT_W-1:0] dabble_adj(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first set req at/after ptr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Scan from farthest to nearest offset so the nearest set request wins last
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(ptr) + off) % N_REQ);
      end
    end
    grant_oh = grant_vld ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/bcd_conv_sched.sv
// ----------------------------------------------------------------------------
// bcd_conv_sched : round-robin shared serial binary-to-BCD (2 digit) converter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIN_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BIN_W-1:0]   bin_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [DIGIT_W-1:0]       bcd1,
  output logic [DIGIT_W-1:0]       bcd0,
  output logic                     ovf
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BIN_W);

  logic [1:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   op;
  logic [DIGIT_W-1:0] d1;
  logic [DIGIT_W-1:0] d0;
  logic               ovf_r;
  logic [IDX_W-1:0]   id_r;

  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [BIN_W-1:0]   win_op;
  logic [7:0]         win_ext;
  logic               win_big;
  logic [BIN_W-1:0]   win_load;
  logic [DIGIT_W-1:0] adj1;
  logic [DIGIT_W-1:0] adj0;
  logic [7:0]         shifted;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant_oh  (win_oh),
    .grant_idx (win_idx),
    .grant_vld (win_vld)
  );

  // Out-of-range operands are clamped so the engine always yields 9,9
  assign win_op   = bin_in[win_idx*BIN_W +: BIN_W];
  assign win_ext  = 8'(win_op);
  assign win_big  = (win_ext >= 8'(BCD_MAX + 1));
  assign win_load = win_big ? BIN_W'(BCD_MAX) : win_op;

  assign adj1    = dabble_adj(d1);
  assign adj0    = dabble_adj(d0);
  assign shifted = {adj1[DIGIT_W-2:0], adj0, op[BIN_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      op      <= '0;
      d1      <= '0;
      d0      <= '0;
      ovf_r   <= 1'b0;
      id_r    <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      bcd1    <= '0;
      bcd0    <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (win_vld) begin
            gnt   <= win_oh;
            busy  <= 1'b1;
            ptr   <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            cnt   <= '0;
            d1    <= '0;
            d0    <= '0;
            op    <= win_load;
            ovf_r <= win_big;
            id_r  <= win_idx;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          gnt      <= '0;
          {d1, d0} <= shifted;
          op       <= op << 1;
          cnt      <= cnt + CNT_W'(1);
          // Final iteration publishes straight to the output registers
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            bcd1    <= shifted[7:4];
            bcd0    <= shifted[3:0];
            ovf     <= ovf_r;
            done_id <= id_r;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
// ----------------------------------------------------------------------------
// tb_bcd_conv_sched : directed self-checking bench for bcd_conv_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_conv_sched;

  localparam int N_REQ = 4;
  localparam int BIN_W = 7;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*BIN_W-1:0] bin_in = '0;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic [1:0]             done_id;
  logic [3:0]             bcd1;
  logic [3:0]             bcd0;
  logic                   ovf;

  bcd_conv_sched #(.N_REQ(N_REQ), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .bcd1(bcd1), .bcd0(bcd0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit inflight = 1'b0;

  always @(posedge clk) cyc++;

  // Continuous protocol watch: no gnt/done overlap, busy spans gnt..done
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) inflight = 1'b0;
      if (gnt != '0) inflight = 1'b1;
      n_checks++;
      if ((gnt != '0) && done) $display("FAIL gnt_done_overlap at cyc %0d: gnt=%b done=%b, required not both", cyc, gnt, done);
      else n_pass++;
      n_checks++;
      if (busy !== inflight) $display("FAIL busy_window at cyc %0d: busy=%b required %b", cyc, busy, inflight);
      else n_pass++;
      if (done) inflight = 1'b0;
    end
  end

  task automatic set_op(input int i, input int v);
    bin_in[i*BIN_W +: BIN_W] = BIN_W'(v);
  endtask

  task automatic wait_gnt(output logic [N_REQ-1:0] g, output int at);
    g = '0;
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt != '0) begin g = gnt; at = cyc; break; end
    end
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin at = cyc; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (gnt !== 4'b0) $display("FAIL reset_gnt: got %b required 0000", gnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else n_pass++;
    n_checks++; if (done_id !== 2'd0) $display("FAIL reset_done_id: got %0d required 0", done_id); else n_pass++;
    n_checks++; if ({bcd1, bcd0} !== 8'h00) $display("FAIL reset_bcd: got %h required 00", {bcd1, bcd0}); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b required 0", ovf); else n_pass++;
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] g;
    int gat, dat;
    set_op(0, 57);
    req = 4'b0001;
    wait_gnt(g, gat);
    n_checks++; if (g !== 4'b0001) $display("FAIL single_gnt: got %b required 0001", g); else n_pass++;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) $display("FAIL single_gnt_pulse: got %b required 0000", gnt); else n_pass++;
    req = '0;
    wait_done(dat);
    n_checks++; if (dat - gat !== 7) $display("FAIL single_latency: got %0d required 7", dat - gat); else n_pass++;
    n_checks++; if ({bcd1, bcd0} !== 8'h57) $display("FAIL single_bcd: got %h required 57", {bcd1, bcd0}); else n_pass++;
    n_checks++; if (done_id !== 2'd0) $display("FAIL single_id: got %0d required 0", done_id); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL single_ovf: got %b required 0", ovf); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL single_done_pulse: got %b required 0", done); else n_pass++;
    n_checks++; if ({bcd1, bcd0} !== 8'h57) $display("FAIL single_hold: got %h required 57", {bcd1, bcd0}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] g;
    int gat, dat, prev;
    int ops[4]    = '{0, 99, 100, 42};
    logic [7:0] exp_bcd[4] = '{8'h00, 8'h99, 8'h99, 8'h42};
    logic exp_ovf[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, ops[i]);
    req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, gat);
      n_checks++; if (g !== 4'(1 << i)) $display("FAIL b2b_gnt[%0d]: got %b required %b", i, g, 4'(1 << i)); else n_pass++;
      if (i > 0) begin
        n_checks++; if (gat - prev !== 9) $display("FAIL b2b_spacing[%0d]: got %0d required 9", i, gat - prev); else n_pass++;
      end
      prev = gat;
      req[i] = 1'b0;
      wait_done(dat);
      n_checks++; if ({bcd1, bcd0} !== exp_bcd[i]) $display("FAIL b2b_bcd[%0d]: got %h required %h", i, {bcd1, bcd0}, exp_bcd[i]); else n_pass++;
      n_checks++; if (ovf !== exp_ovf[i]) $display("FAIL b2b_ovf[%0d]: got %b required %b", i, ovf, exp_ovf[i]); else n_pass++;
      n_checks++; if (done_id !== 2'(i)) $display("FAIL b2b_id[%0d]: got %0d required %0d", i, done_id, i); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] g;
    int gat, dat;
    int order[4] = '{0, 2, 0, 2};
    do_reset();
    set_op(0, 10); set_op(1, 30); set_op(2, 20); set_op(3, 40);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, gat);
      n_checks++; if (g !== 4'(1 << order[i])) $display("FAIL rr_gnt[%0d]: got %b required %b", i, g, 4'(1 << order[i])); else n_pass++;
    end
    req = '0;
    wait_done(dat);
    n_checks++; if ({bcd1, bcd0} !== 8'h20) $display("FAIL rr_last_bcd: got %h required 20", {bcd1, bcd0}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [N_REQ-1:0] g;
    int gat, dat, seen;
    set_op(0, 50);
    req = 4'b0001;
    wait_gnt(g, gat);
    n_checks++; if (g !== 4'b0001) $display("FAIL mid_gnt: got %b required 0001", g); else n_pass++;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    req = '0;
    #1;
    n_checks++; if ({gnt, busy, done, ovf} !== 7'b0) $display("FAIL mid_reset_ctl: got gnt=%b busy=%b done=%b ovf=%b required all 0", gnt, busy, done, ovf); else n_pass++;
    n_checks++; if ({done_id, bcd1, bcd0} !== 10'b0) $display("FAIL mid_reset_data: got id=%0d bcd=%h required 0/00", done_id, {bcd1, bcd0}); else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL mid_no_done: got %0d done pulses required 0", seen); else n_pass++;
    set_op(1, 13);
    req = 4'b0010;
    wait_gnt(g, gat);
    n_checks++; if (g !== 4'b0010) $display("FAIL mid_after_gnt: got %b required 0010", g); else n_pass++;
    req = '0;
    wait_done(dat);
    n_checks++; if ({bcd1, bcd0} !== 8'h13) $display("FAIL mid_after_bcd: got %h required 13", {bcd1, bcd0}); else n_pass++;
    n_checks++; if (done_id !== 2'd1) $display("FAIL mid_after_id: got %0d required 1", done_id); else n_pass++;
  endtask

  task automatic test_sweep();
    logic [N_REQ-1:0] g;
    int gat, dat, m;
    for (int v = 0; v < 128; v++) begin
      set_op(3, v);
      req = 4'b1000;
      wait_gnt(g, gat);
      n_checks++; if (g !== 4'b1000) $display("FAIL sweep_gnt v=%0d: got %b required 1000", v, g); else n_pass++;
      req = '0;
      wait_done(dat);
      m = (v > 99) ? 99 : v;
      n_checks++; if (dat < 0) $display("FAIL sweep_timeout v=%0d: got no done required done", v); else n_pass++;
      n_checks++; if ({bcd1, bcd0} !== {4'(m / 10), 4'(m % 10)}) $display("FAIL sweep_bcd v=%0d: got %h required %0d", v, {bcd1, bcd0}, m); else n_pass++;
      n_checks++; if (ovf !== (v >= 100)) $display("FAIL sweep_ovf v=%0d: got %b required %b", v, ovf, (v >= 100)); else n_pass++;
      n_checks++; if (done_id !== 2'd3) $display("FAIL sweep_id v=%0d: got %0d required 3", v, done_id); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    test_sweep();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
